// File: rtl/cfu_vec_pkg.sv
// Shared encodings and default geometry for the vector MAC custom function unit.
package cfu_vec_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_LEN_W  = 7;

  typedef enum logic [2:0] {
    OP_SUM        = 3'd0,
    OP_DOT_S      = 3'd1,
    OP_DOT_U      = 3'd2,
    OP_SET_OFFSET = 3'd3,
    OP_STATUS     = 3'd4
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ_A = 3'd1,
    ST_REQ_B = 3'd2,
    ST_ACC   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/cfu_vec_lane_mac.sv
// Combinational reduction of one A word and one B word across all lanes.
module cfu_vec_lane_mac
  import cfu_vec_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [2:0]              op,
  input  logic [LANES*LANE_W-1:0] word_a,
  input  logic [LANES*LANE_W-1:0] word_b,
  input  logic [15:0]             offset,
  output logic [31:0]             lane_sum
);

  logic [LANE_W-1:0] a_l, b_l;
  logic [31:0]       a_u, b_u, a_s, b_s, off_ext;

  // All arithmetic is done modulo 2**32; low bits of a product are sign-agnostic.
  always_comb begin
    lane_sum = '0;
    a_l      = '0;
    b_l      = '0;
    a_u      = '0;
    b_u      = '0;
    a_s      = '0;
    b_s      = '0;
    off_ext  = {{16{offset[15]}}, offset};
    for (int l = 0; l < LANES; l++) begin
      a_l = word_a[l*LANE_W +: LANE_W];
      b_l = word_b[l*LANE_W +: LANE_W];
      a_u = {{(32-LANE_W){1'b0}}, a_l};
      b_u = {{(32-LANE_W){1'b0}}, b_l};
      a_s = {{(32-LANE_W){a_l[LANE_W-1]}}, a_l};
      b_s = {{(32-LANE_W){b_l[LANE_W-1]}}, b_l};
      case (op)
        OP_SUM:   lane_sum = lane_sum + a_u + b_u;
        OP_DOT_S: lane_sum = lane_sum + (a_s + off_ext) * b_s;
        OP_DOT_U: lane_sum = lane_sum + a_u * b_u;
        default:  lane_sum = lane_sum;
      endcase
    end
  end

endmodule

// File: rtl/cfu_vec_mac.sv
// Vector MAC CFU: fetches N word pairs over a Wishbone classic read master
// and returns their lane-wise sum / dot product.
module cfu_vec_mac
  import cfu_vec_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic        clk,
  input  logic        reset,
  // Handshakes: a beat transfers on the rising edge where valid && ready;
  // the sender holds valid and payload stable until that edge.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [29:0] cfu_ram_adr,
  output logic [31:0] cfu_ram_dat_mosi,
  output logic [3:0]  cfu_ram_sel,
  output logic        cfu_ram_cyc,
  output logic        cfu_ram_stb,
  output logic        cfu_ram_we,
  output logic [2:0]  cfu_ram_cti,
  output logic [1:0]  cfu_ram_bte,
  input  logic [31:0] cfu_ram_dat_miso,
  input  logic        cfu_ram_ack,
  input  logic        cfu_ram_err,
  output state_t      dbg_state
);

  state_t            state;
  logic [2:0]        op_q;
  logic [LEN_W-1:0]  len_q, idx, idx_next;
  logic [29:0]       addr_a, addr_b;
  logic [31:0]       acc, acc_next, lane_sum, result;
  logic [31:0]       word_a, word_b;
  logic [15:0]       offset;
  logic              err_q;
  logic [2:0]        op_in;
  logic [LEN_W-1:0]  n_in;
  logic              is_vec_op;
  logic              unused_bits;

  assign op_in       = cmd_payload_function_id[2:0];
  assign n_in        = cmd_payload_function_id[2+LEN_W:3];
  assign is_vec_op   = (op_in == OP_SUM) || (op_in == OP_DOT_S) || (op_in == OP_DOT_U);
  assign unused_bits = ^{cmd_payload_inputs_0[1:0], cmd_payload_inputs_1[1:0]};

  cfu_vec_lane_mac #(.LANES(LANES), .LANE_W(LANE_W)) u_lane_mac (
    .op       (op_q),
    .word_a   (word_a),
    .word_b   (word_b),
    .offset   (offset),
    .lane_sum (lane_sum)
  );

  assign acc_next = acc + lane_sum;
  assign idx_next = idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      len_q  <= '0;
      idx    <= '0;
      addr_a <= '0;
      addr_b <= '0;
      acc    <= '0;
      word_a <= '0;
      word_b <= '0;
      offset <= '0;
      err_q  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_in;
            len_q  <= n_in;
            addr_a <= cmd_payload_inputs_0[31:2];
            addr_b <= cmd_payload_inputs_1[31:2];
            acc    <= '0;
            idx    <= '0;
            result <= '0;
            state  <= (is_vec_op && (n_in != '0)) ? ST_REQ_A : ST_RESP;
            // Side effects of the non-bus ops take place at acceptance.
            if (op_in == OP_SET_OFFSET) begin
              result <= {{16{offset[15]}}, offset};
              offset <= cmd_payload_inputs_0[15:0];
            end
            if (op_in == OP_STATUS) begin
              result <= {31'b0, err_q};
              err_q  <= 1'b0;
            end
          end
        end
        ST_REQ_A: begin
          if (cfu_ram_err) begin
            err_q  <= 1'b1;
            result <= '0;
            state  <= ST_RESP;
          end else if (cfu_ram_ack) begin
            word_a <= cfu_ram_dat_miso;
            state  <= ST_REQ_B;
          end
        end
        ST_REQ_B: begin
          if (cfu_ram_err) begin
            err_q  <= 1'b1;
            result <= '0;
            state  <= ST_RESP;
          end else if (cfu_ram_ack) begin
            word_b <= cfu_ram_dat_miso;
            state  <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc <= acc_next;
          idx <= idx_next;
          if (idx_next == len_q) begin
            result <= acc_next;
            state  <= ST_RESP;
          end else begin
            state <= ST_REQ_A;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready             = (state == ST_IDLE);
  assign rsp_valid             = (state == ST_RESP);
  assign rsp_payload_outputs_0 = result;
  assign dbg_state             = state;

  assign cfu_ram_cyc      = (state == ST_REQ_A) || (state == ST_REQ_B);
  assign cfu_ram_stb      = cfu_ram_cyc;
  assign cfu_ram_adr      = ((state == ST_REQ_B) ? addr_b : addr_a) + {{(30-LEN_W){1'b0}}, idx};
  assign cfu_ram_dat_mosi = '0;
  assign cfu_ram_sel      = 4'b1111;
  assign cfu_ram_we       = 1'b0;
  assign cfu_ram_cti      = 3'b000;
  assign cfu_ram_bte      = 2'b00;

endmodule
